// File: rtl/pfft_prod_norm_round.sv
// pfft_prod_norm_round: normalizes and RNE-rounds the posit fraction product into fraction and exponent
module pfft_prod_norm_round #(
    parameter int PROD_W = 65,
    parameter int FRAC_W = 27,
    parameter int EXP_W  = 10
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] out_frac,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic              out_zero,
    output logic              out_ovf
);
    localparam int LZ_W = $clog2(PROD_W + 1);
    localparam int E_W  = EXP_W + 2;
    localparam logic signed [E_W-1:0] EMAX = E_W'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [E_W-1:0] EMIN = E_W'(-(2 ** (EXP_W - 1)));
    logic                    stall;
    logic [LZ_W-1:0]         lz_c;
    logic                    v1, v2;
    logic [PROD_W-1:0]       prod1, norm2;
    logic [EXP_W-1:0]        exp1;
    logic [LZ_W-1:0]         lz1;
    logic                    sign1, sign2, zero2;
    logic signed [E_W-1:0]   e2, e3;
    logic [FRAC_W-1:0]       f, fr;
    logic                    g, s, up, cy;
    logic                    hi, lo;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    // leading-zero count: the highest set bit wins, PROD_W when the product is zero
    always_comb begin
        lz_c = LZ_W'(PROD_W);
        for (int i = 0; i < PROD_W; i++)
            if (in_prod[i]) lz_c = LZ_W'(PROD_W - 1 - i);
    end
    // stage 1: capture the beat together with its leading-zero count
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            v1    <= 1'b0;
            prod1 <= '0;
            exp1  <= '0;
            sign1 <= 1'b0;
            lz1   <= '0;
        end else if (!stall) begin
            v1    <= in_valid;
            prod1 <= in_prod;
            exp1  <= in_exp;
            sign1 <= in_sign;
            lz1   <= lz_c;
        end
    end
    // stage 2: shift the leading one to the MSB and rebase the exponent onto it
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            v2    <= 1'b0;
            norm2 <= '0;
            e2    <= '0;
            sign2 <= 1'b0;
            zero2 <= 1'b0;
        end else if (!stall) begin
            v2    <= v1;
            norm2 <= prod1 << lz1;
            e2    <= {{2{exp1[EXP_W-1]}}, exp1} + E_W'(PROD_W - 1) - {{(E_W - LZ_W){1'b0}}, lz1};
            sign2 <= sign1;
            zero2 <= lz1 == LZ_W'(PROD_W);
        end
    end
    // round-to-nearest-even below the hidden one, carrying a fraction wrap into the exponent
    always_comb begin
        f        = norm2[PROD_W-2 -: FRAC_W];
        g        = norm2[PROD_W-2-FRAC_W];
        s        = |norm2[PROD_W-3-FRAC_W:0];
        up       = g && (s || f[0]);
        {cy, fr} = {1'b0, f} + (FRAC_W + 1)'(up);
        e3       = e2 + E_W'(cy);
        hi       = e3 > EMAX;
        lo       = e3 < EMIN;
    end
    // stage 3: saturate or flag zero into the output register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            out_valid <= 1'b0;
            out_frac  <= '0;
            out_exp   <= '0;
            out_sign  <= 1'b0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            out_valid <= v2;
            out_sign  <= sign2;
            out_zero  <= zero2;
            out_ovf   <= !zero2 && (hi || lo);
            out_frac  <= zero2 ? '0 : hi ? '1 : lo ? '0 : fr;
            out_exp   <= zero2 ? '0 : hi ? EMAX[EXP_W-1:0] : lo ? EMIN[EXP_W-1:0] : e3[EXP_W-1:0];
        end
    end
endmodule

// File: tb/tb_pfft_prod_norm_round.sv
// tb_pfft_prod_norm_round: directed and randomized checks of the product normalizer against a value-level model
module tb_pfft_prod_norm_round;
    localparam int PROD_W = 65;
    localparam int FRAC_W = 27;
    localparam int EXP_W  = 10;
    localparam logic [PROD_W-1:0] ONE = 1;
    localparam logic [PROD_W-1:0] ONES = '1;
    localparam logic [FRAC_W-1:0] FONES = '1;
    typedef struct packed {
        logic [FRAC_W-1:0] frac;
        logic [EXP_W-1:0]  exp;
        logic              sign;
        logic              zero;
        logic              ovf;
    } res_t;
    logic              ap_clk = 1'b0;
    logic              ap_rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod = '0;
    logic [EXP_W-1:0]  in_exp = '0;
    logic              in_sign = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [FRAC_W-1:0] out_frac;
    logic [EXP_W-1:0]  out_exp;
    logic              out_sign;
    logic              out_zero;
    logic              out_ovf;
    int                n_pass = 0;
    int                n_chk = 0;
    res_t              q[$];

    pfft_prod_norm_round dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_exp(in_exp), .in_sign(in_sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_frac(out_frac), .out_exp(out_exp), .out_sign(out_sign),
        .out_zero(out_zero), .out_ovf(out_ovf)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, want);
    endtask

    // value-level reference: locate the hidden one, round the remainder to FRAC_W bits, saturate
    function automatic res_t model(input logic [PROD_W-1:0] prod, input logic [EXP_W-1:0] e, input logic sg);
        res_t r;
        int p, sh, ex;
        logic [PROD_W:0] one, rem, qq, rr, half;
        r = '0;
        r.sign = sg;
        if (prod == 0) begin
            r.zero = 1'b1;
            return r;
        end
        p = 0;
        for (int i = 0; i < PROD_W; i++) if (prod[i]) p = i;
        one = 1;
        rem = {1'b0, prod} - (one << p);
        if (p <= FRAC_W) qq = rem << (FRAC_W - p);
        else begin
            sh = p - FRAC_W;
            qq = rem >> sh;
            rr = rem - (qq << sh);
            half = one << (sh - 1);
            if (rr > half || (rr == half && qq[0])) qq = qq + 1;
        end
        ex = int'($signed(e)) + p;
        if (qq == (one << FRAC_W)) begin
            qq = 0;
            ex++;
        end
        if (ex > 2 ** (EXP_W - 1) - 1) begin
            r.exp = EXP_W'(2 ** (EXP_W - 1) - 1);
            r.frac = '1;
            r.ovf = 1'b1;
        end else if (ex < -(2 ** (EXP_W - 1))) begin
            r.exp = EXP_W'(-(2 ** (EXP_W - 1)));
            r.ovf = 1'b1;
        end else begin
            r.exp = EXP_W'(ex);
            r.frac = qq[FRAC_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [PROD_W-1:0] rnd_prod();
        logic [95:0] w;
        logic [PROD_W-1:0] p;
        w = {$urandom, $urandom, $urandom};
        p = w[PROD_W-1:0];
        case ($urandom_range(0, 7))
            0: p = '0;
            1: begin p[64] = 1'b1; p[36] = 1'b1; p[35:0] = '0; end
            2: p = ONES;
            default: p = p >> $urandom_range(0, 64);
        endcase
        return p;
    endfunction

    task automatic dir(input string tag, input logic [PROD_W-1:0] p, input logic [EXP_W-1:0] e, input logic sg,
                       input logic [FRAC_W-1:0] ef, input logic [EXP_W-1:0] ee, input logic ez, input logic eo);
        @(posedge ap_clk); #1;
        in_valid = 1'b1; in_prod = p; in_exp = e; in_sign = sg; out_ready = 1'b1;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        @(negedge ap_clk);
        check({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge ap_clk);
        check({tag, "_lat2"}, 64'(out_valid), 64'd0);
        @(negedge ap_clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_res"}, 64'({out_frac, out_exp, out_sign, out_zero, out_ovf}), 64'({ef, ee, sg, ez, eo}));
        check({tag, "_model"}, 64'({out_frac, out_exp, out_sign, out_zero, out_ovf}), 64'(model(p, e, sg)));
    endtask

    // mode 0: random traffic, 1: four beats with out_ready low in cycles 2..6, 2: drain
    task automatic stream(input int ncyc, input int mode);
        int acc;
        acc = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge ap_clk); #1;
            case (mode)
                0: begin in_valid = $urandom_range(0, 3) != 0; out_ready = $urandom_range(0, 3) != 0; end
                1: begin in_valid = acc < 4; out_ready = !(c >= 2 && c <= 6); end
                default: begin in_valid = 1'b0; out_ready = 1'b1; end
            endcase
            in_prod = rnd_prod();
            in_exp = EXP_W'($urandom);
            in_sign = 1'($urandom);
            @(negedge ap_clk);
            check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid) begin
                if (q.size() == 0) check("spurious_beat", 64'(out_valid), 64'd0);
                else begin
                    check("stream_res", 64'({out_frac, out_exp, out_sign, out_zero, out_ovf}), 64'(q[0]));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_prod, in_exp, in_sign));
                acc++;
            end
        end
    endtask

    initial begin
        @(negedge ap_clk);
        check("rst_outs", 64'({out_valid, out_frac, out_exp, out_sign, out_zero, out_ovf}), 64'd0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        dir("t1", ONE, 10'd0, 1'b1, '0, 10'd0, 1'b0, 1'b0);
        dir("t2a", ONE << 64, EXP_W'(-64), 1'b0, '0, 10'd0, 1'b0, 1'b0);
        dir("t2b", (ONE << 64) | (ONE << 63), 10'd0, 1'b0, FRAC_W'(1) << 26, 10'd64, 1'b0, 1'b0);
        dir("t3_tie_even", (ONE << 64) | (ONE << 36), 10'd0, 1'b0, FRAC_W'(0), 10'd64, 1'b0, 1'b0);
        dir("t3_tie_odd", (ONE << 64) | (ONE << 37) | (ONE << 36), 10'd0, 1'b0, FRAC_W'(2), 10'd64, 1'b0, 1'b0);
        dir("t3_sticky", (ONE << 64) | (ONE << 36) | ONE, 10'd0, 1'b1, FRAC_W'(1), 10'd64, 1'b0, 1'b0);
        dir("t4_carry", ONES, 10'd0, 1'b0, '0, 10'd65, 1'b0, 1'b0);
        dir("t4_edge", ONES, 10'd446, 1'b0, '0, 10'd511, 1'b0, 1'b0);
        dir("t4_ovf447", ONES, 10'd447, 1'b1, FONES, 10'd511, 1'b0, 1'b1);
        dir("t4_ovf448", ONES, 10'd448, 1'b0, FONES, 10'd511, 1'b0, 1'b1);
        dir("t5_zero", '0, EXP_W'(-5), 1'b1, '0, 10'd0, 1'b1, 1'b0);
        dir("t5_zero_min", '0, EXP_W'(-512), 1'b0, '0, 10'd0, 1'b1, 1'b0);
        stream(12, 1);
        stream(8, 2);
        check("t6_drained", 64'(q.size()), 64'd0);
        stream(400, 0);
        stream(10, 2);
        check("rand_drained", 64'(q.size()), 64'd0);
        stream(20, 0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b1;
        in_valid = 1'b0;
        q.delete();
        #1;
        check("rst_async", 64'(out_valid), 64'd0);
        @(negedge ap_clk);
        check("rst_held", 64'(out_valid), 64'd0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        stream(8, 2);
        check("rst_no_stale", 64'(q.size()), 64'd0);
        stream(200, 0);
        stream(10, 2);
        check("final_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
